serial_subtractor: RTL and testbench

- Bit-serial subtractor; the inverse of the team's 16-bit ripple-carry adder (same operand widths, borrow in place of carry).
- Computes D = A - B - Bi modulo 2^WIDTH and produces borrow-out Bo, one bit per clock, LSB first.
- Uses a start/busy/done handshake. Intended for area-constrained datapaths where a full-width subtractor is not justified.
- A bench checks it against the combinational adder by confirming that S = D + B + Bi reconstructs A.

---
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bi (mod 2^WIDTH) with borrow-out Bo,
// one bit per clock LSB first, behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_a, bit_b, diff, br_nxt, last;

  assign bit_a  = a_sh[0];
  assign bit_b  = b_sh[0];
  assign diff   = bit_a ^ bit_b ^ br;
  assign br_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept so the inputs may change during RUN;
  // D/Bo only move on the final RUN edge so they hold the previous result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= A;
            b_sh <= B;
            br   <= Bi;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {diff, r_sh[WIDTH-1:1]};
          br   <= br_nxt;
          if (last) begin
            D  <= {diff, r_sh[WIDTH-1:1]};
            Bo <= br_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=16): reset, arithmetic,
// handshake, mid-operation reset and output-hold scenarios.
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bi = 1'b0;
  logic [W-1:0] D;
  logic         Bo;
  logic         busy;
  logic         done;

  int pass_cnt = 0;
  int total    = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bi(Bi),
    .D(D), .Bo(Bo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // All tasks start and end at a negedge; inputs change and outputs are sampled there.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    A = a; B = b; Bi = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; start = 1'b1; A = 16'h1234; B = 16'h0042; Bi = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({D, Bo, busy, done} !== {16'h0, 3'b000}) $display("FAIL reset_outputs: D=%h Bo=%b busy=%b done=%b, want all 0", D, Bo, busy, done); else pass_cnt++;
    start = 1'b0; rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL reset_idle: %0d active cycles, want 0", seen); else pass_cnt++;
  endtask

  task automatic run_vec(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic [W-1:0] exp_d, input logic exp_bo);
    int n;
    logic [W-1:0] s;
    apply(a, b, bi);
    total++; if (busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", nm, busy); else pass_cnt++;
    wait_done(n);
    total++; if (n !== 16) $display("FAIL %s latency: got %0d edges want 16", nm, n); else pass_cnt++;
    total++; if (D !== exp_d || Bo !== exp_bo) $display("FAIL %s result: D=%h Bo=%b want D=%h Bo=%b", nm, D, Bo, exp_d, exp_bo); else pass_cnt++;
    s = D + b + {{(W-1){1'b0}}, bi};
    total++; if (s !== a) $display("FAIL %s adder_recon: got %h want %h", nm, s, a); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s done_width: done=%b busy=%b want 0 0", nm, done, busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    run_vec("basic", 16'd30, 16'd20, 1'b1, 16'd9, 1'b0);
  endtask

  task automatic test_borrow_wrap();
    run_vec("wrap_5_20", 16'd5, 16'd20, 1'b0, 16'hFFF1, 1'b1);
    run_vec("wrap_0_0_bi", 16'd0, 16'd0, 1'b1, 16'hFFFF, 1'b1);
    run_vec("max_max", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, extra;
    apply(16'd100, 16'd1, 1'b0);
    extra = 0;
    repeat (5) begin
      start = 1'b1; A = 16'd7; B = 16'd7;
      @(posedge clk); @(negedge clk);
      if (done) extra++;
    end
    start = 1'b0;
    wait_done(n);
    total++; if (n !== 11) $display("FAIL hs_latency: got %0d want 11", n); else pass_cnt++;
    total++; if (D !== 16'd99 || Bo !== 1'b0) $display("FAIL hs_inflight: D=%0d Bo=%b want 99 0", D, Bo); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    if (done) extra++;
    total++; if (extra !== 0 || busy !== 1'b0) $display("FAIL hs_no_queue: extra_done=%0d busy=%b want 0 0", extra, busy); else pass_cnt++;
    apply(16'd7, 16'd7, 1'b0);
    wait_done(n);
    total++; if (n !== 16 || D !== 16'd0 || Bo !== 1'b0) $display("FAIL hs_second: n=%0d D=%h Bo=%b want 16 0 0", n, D, Bo); else pass_cnt++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, seen;
    apply(16'd50, 16'd10, 1'b0);
    seen = 0;
    repeat (7) begin
      @(posedge clk); @(negedge clk);
      if (done) seen++;
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if ({D, Bo, busy, done} !== {16'h0, 3'b000}) $display("FAIL mid_reset: D=%h Bo=%b busy=%b done=%b want all 0", D, Bo, busy, done); else pass_cnt++;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (done) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_no_done: got %0d done cycles want 0", seen); else pass_cnt++;
    apply(16'd50, 16'd10, 1'b0);
    wait_done(n);
    total++; if (n !== 16 || D !== 16'd40 || Bo !== 1'b0) $display("FAIL mid_restart: n=%0d D=%0d Bo=%b want 16 40 0", n, D, Bo); else pass_cnt++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_hold();
    int bad, n;
    bad = 0; n = 0;
    apply(16'd3, 16'd5, 1'b0);
    while (!done && n < 40) begin
      if (D !== 16'd40) bad++;
      @(posedge clk); @(negedge clk);
      n++;
    end
    total++; if (bad !== 0) $display("FAIL hold_during_run: %0d cycles D moved from 40", bad); else pass_cnt++;
    total++; if (!done || D !== 16'hFFFE || Bo !== 1'b1) $display("FAIL hold_final: done=%b D=%h Bo=%b want 1 fffe 1", done, D, Bo); else pass_cnt++;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    total++; if (D !== 16'hFFFE || Bo !== 1'b1) $display("FAIL hold_idle: D=%h Bo=%b want fffe 1", D, Bo); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow_wrap();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
